// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver, 8 data bits, LSB first, 1 stop bit.
// The line is double-synchronised, the start bit is re-checked at mid-bit to
// reject glitches, and every following bit is sampled at its mid-point.
// Results leave as registered single-cycle pulses.  A byte whose frame is bad
// never reaches data.
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames.  This adds an
// even-parity bit between bit 7 and the stop bit, and drives parity_err.
// Without it the frame is 8N1 and parity_err is constant 0.
//
// Handshake: there is no back-pressure.  data_valid is high for exactly one
// cycle when data has just been loaded with a new good byte.  frame_err and
// parity_err are one-cycle pulses on the same edge instead of data_valid.
// data holds its value between frames.
//
// dbg_state mirrors the FSM state register; the idle encoding is 3'd0.

`timescale 1ns/1ps

module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   // Last count of the half bit used to qualify the start bit.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   // Last count of a full bit period.  The sample is taken on this count.
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // Synchroniser for the asynchronous serial line.
   logic rx_m;
   logic rx_s;

   // FSM and datapath registers, with their next-state values.
   state_t        state,      state_n;
   logic [CW-1:0] cnt,        cnt_n;
   logic [2:0]    idx,        idx_n;
   logic [7:0]    shreg,      shreg_n;
   logic [7:0]    data_q,     data_n;
   logic          valid_q,    valid_n;
   logic          ferr_q,     ferr_n;
`ifdef UART_RX_PARITY_EN
   logic          perr_q,     perr_n;
   logic          par_bad,    par_bad_n;
`endif

   // Two-flop synchroniser.  It resets to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // State register for the FSM, the counters, the shifter and the output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= 3'd0;
         shreg   <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         par_bad <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_n;
         par_bad <= par_bad_n;
`endif
      end
   end

   // Next-state logic: bit timing, sampling, and the result decision at the stop bit.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shreg_n   = shreg;
      data_n    = data_q;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_n    = 1'b0;
      par_bad_n = par_bad;
`endif
      case (state)
         S_IDLE: begin
            // A low synchronised line may be a start bit.
            if (!rx_s) begin
               state_n = S_START;
               cnt_n   = '0;
            end
         end

         S_START: begin
            // Re-check the line at the middle of the start bit.
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = S_DATA;
                  idx_n   = 3'd0;
               end else begin
                  // The low level was a glitch: drop it silently.
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_DATA: begin
            // Counting starts at mid-start, so each full period lands mid-bit.
            if (cnt == BIT_LAST) begin
               shreg_n[idx] = rx_s;
               cnt_n        = '0;
               idx_n        = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (cnt == BIT_LAST) begin
               par_bad_n = rx_s ^ (^shreg);
               cnt_n     = '0;
               state_n   = S_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif

         S_STOP: begin
            // Decide the frame outcome.  Only a clean frame updates data.
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               state_n = S_IDLE;
               ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
               perr_n  = par_bad;
               if (rx_s && !par_bad) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
               end
`else
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
               end
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif
   assign busy       = (state != S_IDLE);
   assign dbg_state  = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: randomized and directed frames for uart_rx_byte.
// A driver serialises frames onto rx.  As each frame is issued, a reference
// model pushes the expected outcome and its arrival cycle into queues.  A
// monitor pops an entry for every result pulse and compares it.

`timescale 1ns/1ps

module tb_uart_rx_byte;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   // Cycles from the rx drive point to the monitor edge that sees the pulse.
   // This is one cycle to edge E, then E+2+C/2+9C (+C with parity).
   localparam int LAT = 1 + 2 + C / 2 + 9 * C + (PAR ? C : 0);

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;
   logic [2:0] dbg_state;

   uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [10:0] exp_q[$];    // {data_valid, frame_err, parity_err, data}
   int          exp_t_q[$];  // cycle at which the monitor must see it
   logic [7:0]  last_good = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the outcome of a frame follows from its fields alone.
   task automatic push_expect(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      logic fe_e, pe_e, v_e;
      fe_e = ~stop_bit;
      pe_e = PAR && (par_bit != (^b));
      v_e  = !fe_e && !pe_e;
      if (v_e) last_good = b;
      exp_q.push_back({v_e, fe_e, pe_e, last_good});
      exp_t_q.push_back(cyc + LAT);
   endtask

   // ---------------- driver tasks (entered just after a posedge) ----------------
   task automatic drive_bit(input logic v);
      rx = v;
      repeat (C) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      rx = 1'b1;
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      push_expect(b, stop_bit, par_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (PAR) drive_bit(par_bit);
      drive_bit(stop_bit);
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 20 * C;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: %0d results outstanding, 0 required", name, exp_q.size());
         exp_q.delete();
         exp_t_q.delete();
      end
   endtask

   // ---------------- monitor ----------------
   // Every result pulse is compared with the next entry the model queued.
   always @(negedge clk) begin
      logic [10:0] e;
      int          t;
      if (!rst && (data_valid || frame_err || parity_err)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got dv=%0b fe=%0b pe=%0b data=0x%0h, none required",
                     data_valid, frame_err, parity_err, data);
         end else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("result", {21'd0, data_valid, frame_err, parity_err, data}, {21'd0, e});
            check("latency", cyc, t);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      logic       sb, pb;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", data, 8'h00);
      check("rst_dv", data_valid, 1'b0);
      check("rst_fe", frame_err, 1'b0);
      check("rst_pe", parity_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg_state, 3'd0);
      rst = 1'b0;
      idle(4);

      // Single byte.
      send_frame(8'hA5, 1'b1, ^8'hA5);
      idle(2 * C);
      drain("single");
      check("single_data", data, 8'hA5);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      idle(2 * C);
      drain("b2b");
      check("b2b_data", data, 8'hFF);

      // Glitch rejection: 5 low cycles.
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("glitch_busy_high", busy, 1'b1);
      idle(3 * C);
      check("glitch_busy_low", busy, 1'b0);
      check("glitch_state", dbg_state, 3'd0);
      check("glitch_data", data, last_good);

      // Framing error.
      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle(2 * C);
      drain("ferr");
      check("ferr_data", data, last_good);

      // Reset during bit 4 of 0x81.
      b = 8'h81;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rx = b[4];
      repeat (C / 2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_data", data, 8'h00);
      check("midrst_dv", data_valid, 1'b0);
      check("midrst_fe", frame_err, 1'b0);
      check("midrst_pe", parity_err, 1'b0);
      check("midrst_busy", busy, 1'b0);
      last_good = 8'h00;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2 * C);
      send_frame(8'h42, 1'b1, ^8'h42);
      idle(2 * C);
      drain("after_rst");
      check("after_rst_data", data, 8'h42);

`ifdef UART_RX_PARITY_EN
      // Parity: good then bad parity on 0x07.
      send_frame(8'h07, 1'b1, 1'b1);
      idle(2 * C);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(2 * C);
      drain("parity");
      check("parity_data", data, 8'h07);
`endif

      // Random frames: mostly good, some framing/parity errors, random gaps.
      for (int n = 0; n < 40; n++) begin
         b  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 7) != 0);
         pb = (^b) ^ ($urandom_range(0, 5) == 0);
         send_frame(b, sb, pb);
         if (!sb) idle(2 * C);
         else if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 20));
      end
      idle(2 * C);
      drain("random");
      check("random_final_data", data, last_good);
      check("final_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial receiver that recovers 8-bit bytes from a single UART line (8N1, LSB first) using an oversampling counter. It feeds the eight-bit register stage: `data` drives the register input directly, and `data_valid` marks the single cycle in which a new byte is present. Framing errors and, optionally, parity errors are flagged with single-cycle pulses, and bad bytes are never presented as valid.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and ≥ 4. Counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `rx`, input, 1: serial line. Idles high; asynchronous to clk.
- `data`, output, 8: last good received byte. Holds its value between frames.
- `data_valid`, output, 1: one-cycle pulse; `data` is new and good in this cycle.
- `frame_err`, output, 1: one-cycle pulse; the stop bit sampled 0.
- `parity_err`, output, 1: one-cycle pulse; parity mismatch. Tied 0 when parity is not compiled in.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- Internal state: FSM, bit-period counter `cnt`, 3-bit bit index, 8-bit shift register.
- **IDLE**:
  - `rx_s` = 0 → go to START, `cnt` = 0.
- **START**:
  - `cnt` increments each cycle.
  - At `cnt` = `CLKS_PER_BIT/2`−1: if `rx_s` = 0 → go to DATA with `cnt` = 0 and index = 0.
  - Otherwise the low level was a glitch → return to IDLE with no pulse.
- **DATA**:
  - At `cnt` = `CLKS_PER_BIT`−1: shift `rx_s` into bit[index] (LSB first), set `cnt` = 0, increment index.
  - After bit 7 → go to PARITY if compiled in, else STOP.
- **PARITY** (optional):
  - At the end of the bit period, sample the parity bit and compare it against the XOR of the 8 data bits (even parity).
  - Record the result, then go to STOP.
- **STOP**:
  - At the end of the bit period, sample the stop bit.
  - Stop = 1 and parity OK: `data` ← shift register and `data_valid` = 1.
  - Stop = 0: `frame_err` = 1 and `data` unchanged.
  - Stop = 1 with parity bad: `parity_err` = 1 and `data` unchanged.
  - If both errors occur, both pulses fire together.
  - Always return to IDLE.
- A line held low after a frame error simply starts a new START qualification.
- Pulses are registered and last exactly one cycle. At most one `data_valid` per frame.

## Timing
- Reset values: `data` = 0x00; `data_valid`, `frame_err`, `parity_err` and `busy` = 0; FSM in IDLE; synchronizer = 1.
- Reset mid-frame aborts the frame: no pulse, `data` is cleared to 0.
- Let edge E be the first clk edge that samples `rx` low. Then:
  - the FSM enters START at E+2 and `busy` rises after E+2;
  - data bit n is sampled at E + 2 + `CLKS_PER_BIT`/2 + (n+1)·`CLKS_PER_BIT`;
  - the stop bit is sampled, and the result pulse is registered, at E + 2 + 9.5·`CLKS_PER_BIT` (add `CLKS_PER_BIT` with parity);
  - the pulse is high for the cycle after that edge, while `busy` is already 0.
- The next frame's start edge is recognised in the cycle immediately after the return to IDLE. Back-to-back frames with a 1-bit stop are supported.
- Input bit-rate tolerance is ±3%, given the mid-bit sampling.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the frame is 8E1, with an even-parity bit between bit 7 and the stop bit;
  - the PARITY state exists;
  - `parity_err` is driven as described above.
- `UART_RX_PARITY_EN` undefined:
  - the frame is 8N1 and the PARITY state is absent;
  - `parity_err` is constant 0;
  - timing is one bit period shorter.

## Test plan
- **Single byte**: `CLKS_PER_BIT`=16, send 0xA5 8N1 → `data_valid` pulses once, 155 cycles after edge E; `data` = 0xA5; no error pulses.
- **Back-to-back**: send 0x00 then 0xFF with no idle gap → two `data_valid` pulses 160 cycles apart; `data` reads 0x00, then 0xFF.
- **Glitch rejection**: drive `rx` low for 5 cycles → `busy` pulses briefly, returns to IDLE, no pulses, `data` unchanged.
- **Framing error**: send 0x3C with stop = 0 → `frame_err` pulses once, `data_valid` stays 0, `data` keeps its previous value.
- **Reset mid-frame**: assert `rst` during bit 4 of 0x81 → all outputs are 0 immediately; after release, a following 0x42 is received correctly.
- **Parity** (`UART_RX_PARITY_EN`): 0x07 sent with parity 1 → `data_valid` and `data` = 0x07. 0x07 sent with parity 0 → `parity_err` pulses and `data` is unchanged.
